// File: rtl/a2g_pkg.sv
// Shared constants for the analog-to-button mapper: default thresholds,
// debounce depth, channel indices and the debounce counter width helper.
package a2g_pkg;

  localparam int TH_HI_DEF     = 2000;
  localparam int TH_LO_DEF     = 1000;
  localparam int DEB_COUNT_DEF = 4;

  localparam int CH_LEFT  = 0;
  localparam int CH_RIGHT = 1;

  // Counter must hold 0..DEB_COUNT-1; one extra code keeps DEB_COUNT=1 at 1 bit.
  function automatic int cnt_w(input int deb_count);
    return $clog2(deb_count + 1);
  endfunction

endpackage

// File: rtl/analog2game_ctrl_if.sv
// Sample input and button/LED output bundle between the XADC sampler
// (master) and the analog2game controller (slave).
interface analog2game_ctrl_if #(
  parameter int N_CH   = 2,
  parameter int DATA_W = 16
);
  logic                   sample_valid;
  logic [N_CH*DATA_W-1:0] sample_data;
  logic [N_CH-1:0]        btn_lr;
  logic [N_CH-1:0]        btn_press;
  logic [N_CH-1:0]        btn_release;
  logic                   chord;
  logic [N_CH-1:0]        led;

  modport master (
    output sample_valid, sample_data,
    input  btn_lr, btn_press, btn_release, chord, led
  );

  modport slave (
    input  sample_valid, sample_data,
    output btn_lr, btn_press, btn_release, chord, led
  );
endinterface

// File: rtl/a2g_channel.sv
// One analog channel: hysteresis comparator into raw_q, then a debounce
// counter that flips the stable level after DEB_COUNT disagreeing samples.
module a2g_channel
  import a2g_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int TH_HI     = TH_HI_DEF,
  parameter int TH_LO     = TH_LO_DEF,
  parameter int DEB_COUNT = DEB_COUNT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic              v_q,
  input  logic [DATA_W-1:0] data,
  output logic              stable,
  output logic              press,
  output logic              rls
);

  localparam int            CW       = cnt_w(DEB_COUNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_COUNT - 1);

  logic          raw_q;
  logic [CW-1:0] cnt;

  // Between the thresholds raw_q holds its previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q <= 1'b0;
    end else if (sample_valid) begin
      if (data >= DATA_W'(TH_HI)) begin
        raw_q <= 1'b1;
      end else if (data <= DATA_W'(TH_LO)) begin
        raw_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
      rls    <= 1'b0;
    end else begin
      press <= 1'b0;
      rls   <= 1'b0;
      if (v_q) begin
        if (raw_q == stable) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          stable <= raw_q;
          cnt    <= '0;
          press  <= raw_q;
          rls    <= ~raw_q;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/analog2game_ctrl.sv
// Maps N_CH ADC channels to debounced buttons with press/release pulses,
// chord detection/masking and LED drive.
module analog2game_ctrl
  import a2g_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int DATA_W    = 16,
  parameter int TH_HI     = TH_HI_DEF,
  parameter int TH_LO     = TH_LO_DEF,
  parameter int DEB_COUNT = DEB_COUNT_DEF,
  parameter int CHORD_EN  = 1,
  parameter int CHORD_MIN = 2
) (
  input logic               CLK100MHZ,
  input logic               CPU_RESETN,
  analog2game_ctrl_if.slave bus
);

  logic            v_q;
  logic [N_CH-1:0] stable;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] rls;
  logic            chord;
  int              pop;

  // Stage-2 enable: the debounce acts on raw_q one cycle after the sample.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      v_q <= 1'b0;
    end else begin
      v_q <= bus.sample_valid;
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    a2g_channel #(
      .DATA_W    (DATA_W),
      .TH_HI     (TH_HI),
      .TH_LO     (TH_LO),
      .DEB_COUNT (DEB_COUNT)
    ) u_ch (
      .clk          (CLK100MHZ),
      .rst_n        (CPU_RESETN),
      .sample_valid (bus.sample_valid),
      .v_q          (v_q),
      .data         (bus.sample_data[ch*DATA_W +: DATA_W]),
      .stable       (stable[ch]),
      .press        (press[ch]),
      .rls          (rls[ch])
    );
  end

  always_comb begin
    pop = 0;
    for (int i = 0; i < N_CH; i++) begin
      pop = pop + int'(stable[i]);
    end
    chord = (CHORD_EN != 0) && (pop >= CHORD_MIN);
  end

  // Pulses follow the unmasked stable levels so chord entry still reports a press.
  assign bus.chord       = chord;
  assign bus.btn_lr      = chord ? '0 : stable;
  assign bus.led         = chord ? '1 : stable;
  assign bus.btn_press   = press;
  assign bus.btn_release = rls;

endmodule

// File: tb/tb_analog2game_ctrl.sv
// Bench for analog2game_ctrl: a 2-channel default instance and a 4-channel
// single-sample-debounce instance driven together against a behavioural model.
module tb_analog2game_ctrl;
  import a2g_pkg::*;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  analog2game_ctrl_if #(.N_CH(2), .DATA_W(DW)) bus_a ();
  analog2game_ctrl_if #(.N_CH(4), .DATA_W(DW)) bus_b ();

  analog2game_ctrl #(.N_CH(2), .DATA_W(DW), .TH_HI(2000), .TH_LO(1000),
                     .DEB_COUNT(4), .CHORD_EN(1), .CHORD_MIN(2)) dut_a (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .bus        (bus_a)
  );

  analog2game_ctrl #(.N_CH(4), .DATA_W(DW), .TH_HI(2000), .TH_LO(1000),
                     .DEB_COUNT(1), .CHORD_EN(1), .CHORD_MIN(3)) dut_b (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .bus        (bus_b)
  );

  typedef struct {
    logic [3:0] st_a, pr_a, rl_a;
    logic [3:0] st_b, pr_b, rl_b;
  } exp_t;

  exp_t pipe[$];
  bit   raw_m[2][4];
  bit   stb_m[2][4];
  int   run_m[2][4];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_t idle;
    for (int u = 0; u < 2; u++)
      for (int c = 0; c < 4; c++) begin
        raw_m[u][c] = 1'b0;
        stb_m[u][c] = 1'b0;
        run_m[u][c] = 0;
      end
    idle = '{default: '0};
    pipe.delete();
    pipe.push_back(idle);
    pipe.push_back(idle);
  endtask

  // A level flips after deb consecutive valid samples whose classification
  // disagrees with it; invalid cycles neither extend nor break the run.
  task automatic model_sample(input bit v, input int d0, input int d1,
                              input int d2, input int d3, output exp_t e);
    int d[4];
    logic [3:0] st[2], pr[2], rl[2];
    d = '{d0, d1, d2, d3};
    for (int u = 0; u < 2; u++) begin
      int nch = (u == 0) ? 2 : 4;
      int deb = (u == 0) ? 4 : 1;
      st[u] = '0; pr[u] = '0; rl[u] = '0;
      for (int c = 0; c < nch; c++) begin
        if (v) begin
          if (d[c] >= 2000) raw_m[u][c] = 1'b1;
          else if (d[c] <= 1000) raw_m[u][c] = 1'b0;
          if (raw_m[u][c] == stb_m[u][c]) run_m[u][c] = 0;
          else begin
            run_m[u][c]++;
            if (run_m[u][c] == deb) begin
              stb_m[u][c] = raw_m[u][c];
              run_m[u][c] = 0;
              if (raw_m[u][c]) pr[u][c] = 1'b1;
              else             rl[u][c] = 1'b1;
            end
          end
        end
        st[u][c] = stb_m[u][c];
      end
    end
    e.st_a = st[0]; e.pr_a = pr[0]; e.rl_a = rl[0];
    e.st_b = st[1]; e.pr_b = pr[1]; e.rl_b = rl[1];
  endtask

  task automatic check_outputs(input exp_t e);
    bit ca, cb;
    ca = $countones(e.st_a[1:0]) >= 2;
    cb = $countones(e.st_b) >= 3;
    chk("a_btn_lr",  bus_a.btn_lr,      ca ? 2'b00 : e.st_a[1:0]);
    chk("a_led",     bus_a.led,         ca ? 2'b11 : e.st_a[1:0]);
    chk("a_chord",   bus_a.chord,       ca);
    chk("a_press",   bus_a.btn_press,   e.pr_a[1:0]);
    chk("a_release", bus_a.btn_release, e.rl_a[1:0]);
    chk("b_btn_lr",  bus_b.btn_lr,      cb ? 4'h0 : e.st_b);
    chk("b_led",     bus_b.led,         cb ? 4'hF : e.st_b);
    chk("b_chord",   bus_b.chord,       cb);
    chk("b_press",   bus_b.btn_press,   e.pr_b);
    chk("b_release", bus_b.btn_release, e.rl_b);
  endtask

  // One clock cycle: drive at posedge+1, check at the following negedge.
  task automatic samp(input bit v, input int c0, input int c1,
                      input int c2 = 0, input int c3 = 0);
    exp_t e;
    bus_a.sample_valid = v;
    bus_b.sample_valid = v;
    bus_a.sample_data  = {c1[DW-1:0], c0[DW-1:0]};
    bus_b.sample_data  = {c3[DW-1:0], c2[DW-1:0], c1[DW-1:0], c0[DW-1:0]};
    model_sample(v, c0, c1, c2, c3, e);
    pipe.push_back(e);
    e = pipe.pop_front();
    @(negedge clk);
    check_outputs(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) samp(1'b0, 0, 0);
  endtask

  function automatic int rnd_level();
    case ($urandom_range(0, 4))
      0:       return int'($urandom_range(0, 999));
      1:       return 1000;
      2:       return int'($urandom_range(1001, 1999));
      3:       return 2000;
      default: return int'($urandom_range(2001, 65535));
    endcase
  endfunction

  initial begin
    bus_a.sample_valid = 1'b0;
    bus_a.sample_data  = '0;
    bus_b.sample_valid = 1'b0;
    bus_b.sample_data  = '0;
    model_reset();

    repeat (3) begin
      @(negedge clk);
      chk("rst_a_lr",  bus_a.btn_lr, 0);
      chk("rst_a_led", bus_a.led, 0);
      chk("rst_b_led", bus_b.led, 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);

    // left press then release
    repeat (4) samp(1'b1, 2500, 0);
    idle(3);
    repeat (4) samp(1'b1, 500, 0);
    idle(3);

    // hysteresis band and exact-threshold samples
    repeat (4) samp(1'b1, 2500, 0);
    repeat (20) samp(1'b1, 1500, 0);
    repeat (4) samp(1'b1, 1000, 0);
    idle(2);
    repeat (4) samp(1'b1, 2000, 0);
    idle(2);
    repeat (4) samp(1'b1, 0, 0);
    idle(3);

    // interrupted run on the right channel, idle gaps in between
    samp(1'b1, 0, 2500); idle(1);
    samp(1'b1, 0, 2500); idle(2);
    samp(1'b1, 0, 2500);
    samp(1'b1, 0, 0);    idle(1);
    samp(1'b1, 0, 2500); idle(3);
    samp(1'b1, 0, 2500);
    samp(1'b1, 0, 2500); idle(1);
    samp(1'b1, 0, 2500);
    idle(3);

    // chord entry and exit
    repeat (4) samp(1'b1, 2500, 2500);
    idle(3);
    repeat (4) samp(1'b1, 2500, 0);
    idle(3);
    repeat (4) samp(1'b1, 0, 0);
    idle(3);

    // four-channel instance: ch0+ch2, then ch3 forms a chord
    samp(1'b1, 2500, 0, 2500, 0);
    idle(2);
    samp(1'b1, 2500, 0, 2500, 2500);
    idle(2);
    samp(1'b1, 0, 0, 0, 0);
    idle(2);

    // asynchronous reset in the middle of a cycle and of a debounce run
    repeat (4) samp(1'b1, 2500, 0);
    idle(2);
    repeat (2) samp(1'b1, 2500, 2500);
    bus_a.sample_valid = 1'b0;
    bus_b.sample_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a_lr",    bus_a.btn_lr, 0);
    chk("async_rst_a_led",   bus_a.led, 0);
    chk("async_rst_a_chord", bus_a.chord, 0);
    chk("async_rst_b_lr",    bus_b.btn_lr, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    repeat (2) samp(1'b1, 0, 2500);
    idle(3);

    for (int i = 0; i < 400; i++)
      samp($urandom_range(0, 9) < 7, rnd_level(), rnd_level(), rnd_level(), rnd_level());
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/analog2game_ctrl.md
Name: analog2game_ctrl

Overview:
Parametrised successor to the two-channel analog-to-button mapper. It takes N_CH packed ADC samples, applies per-channel hysteresis thresholds and a sample-count debounce, and produces stable button levels, one-cycle press/release pulses, a chord (multi-press) indication, and LED drive. It sits between the XADC sampling logic and the game input/FSM logic.

Parameters:
N_CH, 2, number of analog channels; channel 0 = left (bit 0), channel 1 = right (bit 1).
DATA_W, 16, ADC sample width, unsigned.
TH_HI, 2000, a raw press is detected when sample >= TH_HI.
TH_LO, 1000, a raw release is detected when sample <= TH_LO; TH_LO < TH_HI is required.
DEB_COUNT, 4, consecutive valid disagreeing samples needed to flip the stable state; must be >= 1.
CHORD_EN, 1, 1 enables chord detection and masking.
CHORD_MIN, 2, stable-active channel count that constitutes a chord; range 2..N_CH.

Ports:
CLK100MHZ  input  1  system clock, all logic on its rising edge.
CPU_RESETN  input  1  asynchronous, active-low reset.
sample_valid  input  1  qualifies sample_data for one cycle.
sample_data  input  N_CH*DATA_W  packed samples; channel i in bits [i*DATA_W +: DATA_W].
btn_lr  output  N_CH  debounced button levels, masked to 0 during a chord.
btn_press  output  N_CH  one-cycle pulse on the stable 0->1 transition of channel i.
btn_release  output  N_CH  one-cycle pulse on the stable 1->0 transition of channel i.
chord  output  1  high while the chord condition holds.
led  output  N_CH  stable levels; all ones during a chord.

Behaviour:
- Reset: the asynchronous assert of CPU_RESETN=0 clears raw_q, stable, debounce counters, v_q, btn_press, btn_release. Consequently btn_lr=0, led=0, chord=0. Reset mid-debounce discards the partial count.
- Stage 1, on an edge with sample_valid=1, per channel:
  - raw_q <= 1 if data >= TH_HI.
  - raw_q <= 0 if data <= TH_LO.
  - Otherwise raw_q holds (hysteresis band).
  - v_q <= sample_valid on every edge.
- Stage 2, on an edge with v_q=1, per channel:
  - If raw_q == stable: cnt <= 0.
  - Else if cnt == DEB_COUNT-1: stable <= raw_q and cnt <= 0; btn_press or btn_release is set for one cycle according to direction.
  - Else: cnt <= cnt+1.
- Edges with v_q=0 leave cnt and stable unchanged; gaps between samples do not reset the debounce. Press/release pulses are cleared on every edge where no flip occurs.
- Latency: the sample completing the count, presented in cycle t, produces the stable change and its pulse in cycle t+2. With DEB_COUNT=1 a single sample suffices.
- Counter width is clog2(DEB_COUNT+1). The counter never exceeds DEB_COUNT-1, so there is no wrap-around.
- Chord and outputs are combinational from the stable flops:
  - chord = CHORD_EN && popcount(stable) >= CHORD_MIN.
  - btn_lr = chord ? 0 : stable.
  - led = chord ? all ones : stable.
- press/release follow stable, not the masked btn_lr; entering a chord still pulses btn_press for the channel that completed it.
- Channels are independent; simultaneous flips on several channels pulse in the same cycle.
- Samples exactly at TH_HI count as press and samples exactly at TH_LO count as release. Any sample strictly between TH_LO and TH_HI holds the raw state.
- A disagreement run that is interrupted by an agreeing valid sample restarts from 0.

Decomposition:
- Package a2g_pkg: default thresholds, DEB_COUNT default, a clog2-based counter-width function, and a channel-index constants pair (CH_LEFT=0, CH_RIGHT=1).
- Sub-module a2g_channel holds one channel's hysteresis comparator, raw_q, debounce counter, stable flop and press/release pulses.
- It is instantiated N_CH times by a generate loop. The top level adds v_q, popcount, chord masking and LED mapping.

Test Plan:
- Reset and idle: hold CPU_RESETN=0, then release with no samples -> all outputs 0; assert reset asynchronously mid-cycle -> outputs clear before the next edge.
- Left press/release: DEB_COUNT=4, ch0=2500, ch1=0, 4 valid samples -> btn_lr=01, led=01, btn_press[0] high exactly 1 cycle, 2 cycles after the 4th sample. Then ch0=500 for 4 samples -> btn_lr=00, btn_release[0] pulse.
- Hysteresis band: after ch0 is stable-pressed, send 20 samples of 1500 -> btn_lr stays 01 with no pulses. Samples of exactly 1000 x4 -> release; exactly 2000 x4 -> press.
- Debounce reject: ch1 samples 2500,2500,2500,0,2500,2500,2500 -> no press. A 4th consecutive 2500 -> press. Idle cycles (sample_valid=0) inserted between samples do not change the result.
- Chord: both channels 2500 for 4 samples -> btn_lr=00, led=11, chord=1, btn_press=11 for one cycle. ch1 dropped to 0 x4 -> chord=0, btn_lr=01, btn_release[1] pulse.
- Generic config: N_CH=4, CHORD_MIN=3, DEB_COUNT=1 -> one sample pressing ch0 and ch2 gives btn_lr=0101. Adding ch3 gives chord=1, btn_lr=0000, led=1111.
